// File: rtl/psram_wb32_bridge.sv
// rtl/psram_wb32_bridge.sv - 32-to-16 bit Wishbone bridge for the PSRAM slave; PSRAM_BRIDGE_SKIP_EN skips beats whose select pair is 2'b00
module psram_wb32_bridge (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  output logic [1:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [15:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [2:0] {S_IDLE, S_HI, S_GAP, S_LO, S_DONE} state_t;

  state_t      r_state, w_state;
  logic [29:0] r_adr;
  logic [15:0] r_dat_lo;
  logic [1:0]  r_sel_lo;
  logic        r_we;
  logic        r_abort;
  logic [15:0] r_hi, w_hi;
  logic [31:0] r_rdat, w_rdat;
  logic        r_ack, w_ack;
  logic [31:0] r_madr, w_madr;
  logic [15:0] r_mdat, w_mdat;
  logic [1:0]  r_msel, w_msel;
  logic        r_mwe, w_mwe;
  logic        r_mcyc, w_mcyc;
  logic        r_mstb, w_mstb;
  logic        w_start;
  logic        w_abort;
  logic        w_unused;

  assign w_unused = &{1'b0, wbs_adr_i[1:0]};
  assign w_start  = (r_state == S_IDLE) && wbs_cyc_i && wbs_stb_i;
  // Once the master drops cyc mid-transfer, the current beat still finishes.
  assign w_abort  = r_abort || !wbs_cyc_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_adr    <= '0;
      r_dat_lo <= '0;
      r_sel_lo <= '0;
      r_we     <= 1'b0;
      r_abort  <= 1'b0;
      r_hi     <= '0;
      r_rdat   <= '0;
      r_ack    <= 1'b0;
      r_madr   <= '0;
      r_mdat   <= '0;
      r_msel   <= '0;
      r_mwe    <= 1'b0;
      r_mcyc   <= 1'b0;
      r_mstb   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_hi    <= w_hi;
      r_rdat  <= w_rdat;
      r_ack   <= w_ack;
      r_madr  <= w_madr;
      r_mdat  <= w_mdat;
      r_msel  <= w_msel;
      r_mwe   <= w_mwe;
      r_mcyc  <= w_mcyc;
      r_mstb  <= w_mstb;
      r_abort <= ((r_state == S_HI) || (r_state == S_LO)) ? w_abort : 1'b0;
      if (w_start) begin
        r_adr    <= wbs_adr_i[31:2];
        r_dat_lo <= wbs_dat_i[15:0];
        r_sel_lo <= wbs_sel_i[1:0];
        r_we     <= wbs_we_i;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_hi    = r_hi;
    w_rdat  = r_rdat;
    w_ack   = 1'b0;
    w_madr  = r_madr;
    w_mdat  = r_mdat;
    w_msel  = r_msel;
    w_mwe   = r_mwe;
    w_mcyc  = r_mcyc;
    w_mstb  = r_mstb;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_hi  = 16'h0000;
          w_mwe = wbs_we_i;
          w_state = S_HI;
          w_mcyc  = 1'b1;
          w_mstb  = 1'b1;
          w_madr  = {1'b0, wbs_adr_i[31:2], 1'b0};
          w_mdat  = wbs_dat_i[31:16];
          w_msel  = wbs_sel_i[3:2];
`ifdef PSRAM_BRIDGE_SKIP_EN
          if (wbs_sel_i == 4'b0000) begin
            // No beat at all: pass through GAP so the ack lands two cycles after the request.
            w_state = S_GAP;
            w_mcyc  = 1'b0;
            w_mstb  = 1'b0;
            w_mwe   = 1'b0;
            w_madr  = r_madr;
            w_mdat  = r_mdat;
            w_msel  = r_msel;
          end else if (wbs_sel_i[3:2] == 2'b00) begin
            w_state = S_LO;
            w_madr  = {1'b0, wbs_adr_i[31:2], 1'b1};
            w_mdat  = wbs_dat_i[15:0];
            w_msel  = wbs_sel_i[1:0];
          end
`endif
        end
      end
      S_HI: begin
        if (wbm_ack_i) begin
          w_hi   = wbm_dat_i;
          w_mstb = 1'b0;
          w_state = S_GAP;
          if (w_abort) begin
            w_mcyc  = 1'b0;
            w_mwe   = 1'b0;
            w_state = S_DONE;
          end
`ifdef PSRAM_BRIDGE_SKIP_EN
          else if (r_sel_lo == 2'b00) begin
            w_mcyc  = 1'b0;
            w_mwe   = 1'b0;
            w_ack   = 1'b1;
            w_state = S_DONE;
            if (!r_we) begin
              w_rdat = {wbm_dat_i, 16'h0000};
            end
          end
`endif
        end
      end
      S_GAP: begin
        if (!wbm_ack_i) begin
          w_state = S_LO;
          w_mstb  = 1'b1;
          w_madr  = {1'b0, r_adr, 1'b1};
          w_mdat  = r_dat_lo;
          w_msel  = r_sel_lo;
`ifdef PSRAM_BRIDGE_SKIP_EN
          // GAP with an empty low select is only reachable from the all-zero request.
          if (r_sel_lo == 2'b00) begin
            w_state = S_DONE;
            w_mstb  = 1'b0;
            w_madr  = r_madr;
            w_mdat  = r_mdat;
            w_msel  = r_msel;
            w_ack   = 1'b1;
            if (!r_we) begin
              w_rdat = 32'h0000_0000;
            end
          end
`endif
        end
      end
      S_LO: begin
        if (wbm_ack_i) begin
          w_mstb  = 1'b0;
          w_mcyc  = 1'b0;
          w_mwe   = 1'b0;
          w_state = S_DONE;
          if (!w_abort) begin
            w_ack = 1'b1;
            if (!r_we) begin
              w_rdat = {r_hi, wbm_dat_i};
            end
          end
        end
      end
      S_DONE: begin
        if (!wbm_ack_i) begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign wbs_dat_o = r_rdat;
  assign wbs_ack_o = r_ack;
  assign wbm_adr_o = r_madr;
  assign wbm_dat_o = r_mdat;
  assign wbm_sel_o = r_msel;
  assign wbm_we_o  = r_mwe;
  assign wbm_cyc_o = r_mcyc;
  assign wbm_stb_o = r_mstb;

endmodule

// File: tb/tb_psram_wb32_bridge.sv
// tb/tb_psram_wb32_bridge.sv - directed bench for psram_wb32_bridge
module tb_psram_wb32_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic [31:0] wbm_adr_o;
  logic [15:0] wbm_dat_o;
  logic [1:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [15:0] wbm_dat_i;
  logic        wbm_ack_i;

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;

  psram_wb32_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (wbs_ack_o === 1'b1) ack_cnt++;
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we);
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_we_i  = we;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
  endtask

  task automatic release_bus;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] adr, input logic [15:0] dat,
                      input logic [1:0] sel, input logic we, input logic [15:0] rd,
                      input int hold, output logic got_ack);
    for (int i = 0; i < 20 && wbm_stb_o !== 1'b1; i++) tick();
    chk({tag, "_stb"}, {31'd0, wbm_stb_o}, 32'd1);
    chk({tag, "_cyc"}, {31'd0, wbm_cyc_o}, 32'd1);
    chk({tag, "_adr"}, wbm_adr_o, adr);
    chk({tag, "_sel"}, {30'd0, wbm_sel_o}, {30'd0, sel});
    chk({tag, "_we"}, {31'd0, wbm_we_o}, {31'd0, we});
    if (we) chk({tag, "_dat"}, {16'd0, wbm_dat_o}, {16'd0, dat});
    wbm_dat_i = rd;
    wbm_ack_i = 1'b1;
    tick();
    got_ack = wbs_ack_o;
    chk({tag, "_stb_drop"}, {31'd0, wbm_stb_o}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_gap_hold"}, {31'd0, wbm_stb_o}, 32'd0);
    end
    wbm_ack_i = 1'b0;
    wbm_dat_i = 16'h0000;
  endtask

  logic got;
  int   base;

  initial begin
    rst_i = 1'b1;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 16'h0000;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    wbs_sel_i = '0;
    wbs_we_i  = 1'b0;
    release_bus();
    tick();
    tick();
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_mdat", {16'd0, wbm_dat_o}, 32'h0);
    chk("rst_sel", {30'd0, wbm_sel_o}, 32'h0);
    chk("rst_we", {31'd0, wbm_we_o}, 32'd0);
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // full-word write
    base = ack_cnt;
    request(32'h100, 32'h1234_5678, 4'hF, 1'b1);
    beat("w_hi", 32'h80, 16'h1234, 2'b11, 1'b1, 16'h0, 0, got);
    chk("w_hi_noack", {31'd0, got}, 32'd0);
    beat("w_lo", 32'h81, 16'h5678, 2'b11, 1'b1, 16'h0, 0, got);
    chk("w_ack", {31'd0, got}, 32'd1);
    chk("w_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
    release_bus();
    tick();
    chk("w_ack_pulse", {31'd0, wbs_ack_o}, 32'd0);
    tick();
    chk("w_ack_count", ack_cnt - base, 32'd1);
    chk("w_dat_o_kept", wbs_dat_o, 32'h0);

    // read with the slave holding ack through GAP
    base = ack_cnt;
    request(32'h204, 32'h0, 4'hF, 1'b0);
    beat("r_hi", 32'h102, 16'h0, 2'b11, 1'b0, 16'hCAFE, 3, got);
    beat("r_lo", 32'h103, 16'h0, 2'b11, 1'b0, 16'hBEEF, 0, got);
    chk("r_ack", {31'd0, got}, 32'd1);
    chk("r_data", wbs_dat_o, 32'hCAFE_BEEF);
    release_bus();
    tick();
    tick();
    chk("r_ack_count", ack_cnt - base, 32'd1);
    chk("r_data_hold", wbs_dat_o, 32'hCAFE_BEEF);

    // low-half-only select
    request(32'h300, 32'hAAAA_5555, 4'b0011, 1'b1);
`ifdef PSRAM_BRIDGE_SKIP_EN
    beat("s_lo", 32'h181, 16'h5555, 2'b11, 1'b1, 16'h0, 0, got);
    chk("s_ack", {31'd0, got}, 32'd1);
    release_bus();
    tick();
    tick();
    request(32'h300, 32'h0, 4'b0011, 1'b0);
    beat("sr_lo", 32'h181, 16'h0, 2'b11, 1'b0, 16'h1357, 0, got);
    chk("sr_ack", {31'd0, got}, 32'd1);
    chk("sr_data", wbs_dat_o, 32'h0000_1357);
    release_bus();
    tick();
    tick();
`else
    beat("s_hi", 32'h180, 16'hAAAA, 2'b00, 1'b1, 16'h0, 0, got);
    beat("s_lo", 32'h181, 16'h5555, 2'b11, 1'b1, 16'h0, 0, got);
    chk("s_ack", {31'd0, got}, 32'd1);
    release_bus();
    tick();
    tick();
`endif

    // abort: cyc dropped while the high beat is outstanding
    base = ack_cnt;
    request(32'h400, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 20 && wbm_stb_o !== 1'b1; i++) tick();
    chk("a_hi_stb", {31'd0, wbm_stb_o}, 32'd1);
    chk("a_hi_adr", wbm_adr_o, 32'h200);
    release_bus();
    tick();
    chk("a_hi_still", {31'd0, wbm_stb_o}, 32'd1);
    wbm_dat_i = 16'h1111;
    wbm_ack_i = 1'b1;
    tick();
    chk("a_stb_drop", {31'd0, wbm_stb_o}, 32'd0);
    chk("a_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
    wbm_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("a_no_lo", {31'd0, wbm_stb_o}, 32'd0);
    end
    chk("a_no_ack", ack_cnt - base, 32'd0);
    chk("a_dat_kept", wbs_dat_o, 32'hCAFE_BEEF);

    // reset while the low beat is outstanding
    base = ack_cnt;
    request(32'h500, 32'hDEAD_BEEF, 4'hF, 1'b1);
    beat("x_hi", 32'h280, 16'hDEAD, 2'b11, 1'b1, 16'h0, 0, got);
    for (int i = 0; i < 20 && wbm_stb_o !== 1'b1; i++) tick();
    chk("x_lo_stb", {31'd0, wbm_stb_o}, 32'd1);
    chk("x_lo_adr", wbm_adr_o, 32'h281);
    rst_i = 1'b1;
    release_bus();
    tick();
    chk("x_stb", {31'd0, wbm_stb_o}, 32'd0);
    chk("x_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("x_adr", wbm_adr_o, 32'h0);
    chk("x_mdat", {16'd0, wbm_dat_o}, 32'h0);
    chk("x_we", {31'd0, wbm_we_o}, 32'd0);
    chk("x_dat_o", wbs_dat_o, 32'h0);
    rst_i = 1'b0;
    tick();
    chk("x_no_ack", ack_cnt - base, 32'd0);

    request(32'h8, 32'h0, 4'hF, 1'b0);
    beat("p_hi", 32'h4, 16'h0, 2'b11, 1'b0, 16'h0102, 0, got);
    beat("p_lo", 32'h5, 16'h0, 2'b11, 1'b0, 16'h0304, 0, got);
    chk("p_ack", {31'd0, got}, 32'd1);
    chk("p_data", wbs_dat_o, 32'h0102_0304);
    release_bus();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
